// File: rtl/fetch_queue_pkg.sv
// Shared types for the two-wide fetch stage and its instruction queue.
// Fetch-decode control packets, queue entry layout and fetch FSM states.
package fetch_queue_pkg;

    localparam int FETCH_WIDTH = 2;

    typedef struct packed {
        logic branch;
        logic cond_branch;
        logic uncond_branch;
        logic halt;
        logic illegal;
    } FD_control_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        FD_control_t ctrl;
    } fetch_entry_t;

    typedef enum logic {
        FETCH,
        HALTED
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction memory port of the fetch stage, carrying the returned pair
// together with its per-slot fetch-decode control packets.
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic [63:0] proc2imem_addr;
    logic [63:0] imem2proc_data;
    logic        imem2proc_valid;
    FD_control_t fd_ctrl0;
    FD_control_t fd_ctrl1;

    modport master (
        output proc2imem_addr,
        input  imem2proc_data,
        input  imem2proc_valid,
        input  fd_ctrl0,
        input  fd_ctrl1
    );

    modport slave (
        input  proc2imem_addr,
        output imem2proc_data,
        output imem2proc_valid,
        output fd_ctrl0,
        output fd_ctrl1
    );

endinterface

// File: rtl/fetch_group_select.sv
// Combinational fetch-group former: picks the kept slots of the returned
// pair, the group size, the fall-through next pc and whether a halt ends it.
module fetch_group_select
    import fetch_queue_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic [PC_W-1:0] pc,
    input  FD_control_t     ctrl0,
    input  FD_control_t     ctrl1,
    output logic [1:0]      keep,
    output logic [1:0]      size,
    output logic [PC_W-1:0] next_pc,
    output logic            halt_seen
);

    logic [PC_W-1:0] line;
    logic            cand0;
    logic            stop0;
    logic            unused_bits;

    assign line  = {pc[PC_W-1:3], 3'b000};
    assign cand0 = ~pc[2];
    assign stop0 = cand0 & (ctrl0.branch | ctrl0.halt);

    // Only branch/halt steer grouping; the rest of the packet rides along.
    assign unused_bits = ^{pc[1:0], ctrl0, ctrl1};

    always_comb begin
        keep      = 2'b10;
        size      = 2'd1;
        next_pc   = line + PC_W'(8);
        halt_seen = ctrl1.halt;
        if (stop0) begin
            keep      = 2'b01;
            size      = 2'd1;
            next_pc   = line + PC_W'(4);
            halt_seen = ctrl0.halt;
        end else if (cand0) begin
            keep = 2'b11;
            size = 2'd2;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Two-wide fetch stage and circular instruction queue feeding dispatch.
// Groups are enqueued whole or not at all; redirect flushes and restarts.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH = 8,
    parameter int PC_W        = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    fetch_queue_if.master                imem,
    input  logic                         redirect_valid,
    input  logic [PC_W-1:0]              redirect_pc,
    input  logic [1:0]                   deq_count,
    output logic [31:0]                  out_inst [FETCH_WIDTH],
    output logic [PC_W-1:0]              out_pc   [FETCH_WIDTH],
    output FD_control_t                  out_ctrl [FETCH_WIDTH],
    output logic [1:0]                   out_valid,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count,
    output logic                         halted
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] grp_next_pc;
    logic [PC_W-1:0] line;
    logic [1:0]      keep;
    logic [1:0]      grp_size;
    logic            halt_seen;
    logic            enq;
    logic [1:0]      enq_n;
    logic [1:0]      deq_n;
    logic [1:0]      avail;
    logic [CW-1:0]   free;

    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CW-1:0]   count;
    fetch_entry_t    mem [QUEUE_DEPTH];
    fetch_entry_t    wr0;
    fetch_entry_t    wr1;

    fetch_group_select #(
        .PC_W (PC_W)
    ) u_sel (
        .pc        (pc),
        .ctrl0     (imem.fd_ctrl0),
        .ctrl1     (imem.fd_ctrl1),
        .keep      (keep),
        .size      (grp_size),
        .next_pc   (grp_next_pc),
        .halt_seen (halt_seen)
    );

    assign line = {pc[PC_W-1:3], 3'b000};
    assign free = CW'(QUEUE_DEPTH) - count;
    assign enq  = (state == FETCH) && imem.imem2proc_valid
                  && (free >= CW'(grp_size));

    assign enq_n = (enq && !redirect_valid) ? grp_size : 2'd0;
    assign deq_n = redirect_valid ? 2'd0 : deq_count;

    // Kept slots are packed contiguously starting at tail.
    always_comb begin
        wr0 = '{inst: imem.imem2proc_data[31:0],
                pc:   64'(line),
                ctrl: imem.fd_ctrl0};
        wr1 = '{inst: imem.imem2proc_data[63:32],
                pc:   64'(line + PC_W'(4)),
                ctrl: imem.fd_ctrl1};
        if (!keep[0]) begin
            wr0 = wr1;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (redirect_valid) begin
            state_next = FETCH;
            pc_next    = redirect_pc;
        end else if (enq) begin
            pc_next = grp_next_pc;
            if (halt_seen) begin
                state_next = HALTED;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
            pc    <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (redirect_valid) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + AW'(deq_n);
                tail  <= tail + AW'(enq_n);
                count <= count + CW'(enq_n) - CW'(deq_n);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && enq_n != 2'd0) begin
            mem[tail] <= wr0;
            if (enq_n == 2'd2) begin
                mem[tail + AW'(1)] <= wr1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            out_inst[i] = mem[head + AW'(i)].inst;
            out_pc[i]   = PC_W'(mem[head + AW'(i)].pc);
            out_ctrl[i] = mem[head + AW'(i)].ctrl;
        end
    end

    assign out_valid = (count == '0)      ? 2'b00 :
                       (count == CW'(1))  ? 2'b01 : 2'b11;
    assign avail     = out_valid[1] ? 2'd2 : {1'b0, out_valid[0]};

    assign queue_count         = count;
    assign halted              = (state == HALTED);
    assign imem.proc2imem_addr = 64'(line);

    assert property (@(posedge clock) disable iff (reset)
        deq_count <= avail);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: expected entries go into a scoreboard
// that a negedge monitor drains whenever dispatch dequeues.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [1:0]  deq_count;
    logic [31:0] out_inst [2];
    logic [63:0] out_pc   [2];
    FD_control_t out_ctrl [2];
    logic [1:0]  out_valid;
    logic [3:0]  queue_count;
    logic        halted;

    FD_control_t alu_c;
    FD_control_t br_c;
    FD_control_t hlt_c;

    int errors = 0;
    int checks = 0;
    fetch_entry_t exp_q [$];

    always #5 clock = ~clock;

    fetch_queue_if imem ();

    fetch_queue #(
        .QUEUE_DEPTH (8),
        .PC_W        (64)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem           (imem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq_count      (deq_count),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_ctrl       (out_ctrl),
        .out_valid      (out_valid),
        .queue_count    (queue_count),
        .halted         (halted)
    );

    function automatic logic [31:0] mk(input logic [63:0] p);
        return 32'h1300_0000 | p[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic go(input logic v, input logic [63:0] line,
                      input FD_control_t c0, input FD_control_t c1,
                      input logic [1:0] deq, input logic red,
                      input logic [63:0] rpc);
        @(posedge clock);
        #1;
        imem.imem2proc_valid = v;
        imem.imem2proc_data  = {mk(line + 64'd4), mk(line)};
        imem.fd_ctrl0        = c0;
        imem.fd_ctrl1        = c1;
        deq_count            = deq;
        redirect_valid       = red;
        redirect_pc          = rpc;
    endtask

    task automatic idle(input logic [1:0] deq);
        go(1'b0, 64'h0, alu_c, alu_c, deq, 1'b0, 64'h0);
    endtask

    task automatic fetch(input logic [63:0] line, input FD_control_t c0,
                         input FD_control_t c1, input logic [1:0] deq);
        go(1'b1, line, c0, c1, deq, 1'b0, 64'h0);
    endtask

    task automatic redir(input logic [63:0] rpc, input logic [1:0] deq);
        go(1'b0, 64'h0, alu_c, alu_c, deq, 1'b1, rpc);
        exp_q.delete();
    endtask

    task automatic expect_e(input logic [63:0] p, input FD_control_t c);
        exp_q.push_back('{inst: mk(p), pc: p, ctrl: c});
    endtask

    task automatic peek(input string tag, input logic [63:0] addr,
                        input logic [3:0] cnt, input logic hlt);
        @(negedge clock);
        check({tag, "_addr"}, imem.proc2imem_addr, addr);
        check({tag, "_count"}, 64'(queue_count), 64'(cnt));
        check({tag, "_halted"}, 64'(halted), 64'(hlt));
    endtask

    always @(negedge clock) begin
        if (!reset && !redirect_valid) begin
            for (int i = 0; i < int'(deq_count); i++) begin
                fetch_entry_t e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL deq%0d: popped pc %0h, none expected",
                             i, out_pc[i]);
                end else begin
                    e = exp_q.pop_front();
                    if (out_inst[i] !== e.inst || out_pc[i] !== e.pc
                        || out_ctrl[i] !== e.ctrl) begin
                        errors++;
                        $display("FAIL deq%0d: got pc %0h inst %0h ctrl %0h expected pc %0h inst %0h ctrl %0h",
                                 i, out_pc[i], out_inst[i], out_ctrl[i],
                                 e.pc, e.inst, e.ctrl);
                    end
                end
            end
        end
    end

    initial begin
        alu_c = '0;
        br_c  = '0;
        br_c.branch = 1'b1;
        br_c.cond_branch = 1'b1;
        hlt_c = '0;
        hlt_c.halt = 1'b1;

        reset                = 1'b1;
        redirect_valid       = 1'b0;
        redirect_pc          = '0;
        deq_count            = '0;
        imem.imem2proc_valid = 1'b0;
        imem.imem2proc_data  = '0;
        imem.fd_ctrl0        = '0;
        imem.fd_ctrl1        = '0;

        @(posedge clock);
        peek("reset", 64'h0, 4'd0, 1'b0);
        check("reset_out_valid", 64'(out_valid), 64'h0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Aligned pair of ALU ops
        fetch(64'h0, alu_c, alu_c, 2'd0);
        expect_e(64'h0, alu_c);
        expect_e(64'h4, alu_c);
        peek("t1_pre", 64'h0, 4'd0, 1'b0);
        idle(2'd0);
        peek("t1", 64'h8, 4'd2, 1'b0);
        check("t1_out_valid", 64'(out_valid), 64'h3);
        idle(2'd2);
        idle(2'd0);
        peek("t1_drain", 64'h8, 4'd0, 1'b0);
        check("t1_drain_valid", 64'(out_valid), 64'h0);

        // Odd restart pc keeps slot1 only
        redir(64'h104, 2'd0);
        fetch(64'h100, alu_c, alu_c, 2'd0);
        expect_e(64'h104, alu_c);
        peek("t2_pre", 64'h100, 4'd0, 1'b0);
        idle(2'd0);
        peek("t2", 64'h108, 4'd1, 1'b0);
        check("t2_out_valid", 64'(out_valid), 64'h1);
        idle(2'd1);

        // Branch in slot0 ends the group
        redir(64'h10, 2'd0);
        fetch(64'h10, br_c, alu_c, 2'd0);
        expect_e(64'h10, br_c);
        fetch(64'h10, alu_c, alu_c, 2'd0);
        expect_e(64'h14, alu_c);
        peek("t3_br", 64'h10, 4'd1, 1'b0);
        idle(2'd0);
        peek("t3", 64'h18, 4'd2, 1'b0);
        idle(2'd2);

        // Halt in slot0 freezes fetch
        redir(64'h20, 2'd0);
        fetch(64'h20, hlt_c, alu_c, 2'd0);
        expect_e(64'h20, hlt_c);
        for (int k = 0; k < 5; k++) begin
            fetch(64'h20, alu_c, alu_c, 2'd0);
            peek($sformatf("t4_frozen%0d", k), 64'h20, 4'd1, 1'b1);
        end
        idle(2'd1);
        idle(2'd0);
        peek("t4_deq", 64'h20, 4'd0, 1'b1);

        // Fill to 7, full group stalls, then fits after one dequeue
        redir(64'h104, 2'd0);
        fetch(64'h100, alu_c, alu_c, 2'd0);
        expect_e(64'h104, alu_c);
        peek("t5_unhalt", 64'h100, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            fetch(64'h108 + 64'(k * 8), alu_c, alu_c, 2'd0);
            expect_e(64'h108 + 64'(k * 8), alu_c);
            expect_e(64'h10c + 64'(k * 8), alu_c);
        end
        fetch(64'h120, alu_c, alu_c, 2'd1);
        peek("t5_seven", 64'h120, 4'd7, 1'b0);
        fetch(64'h120, alu_c, alu_c, 2'd0);
        expect_e(64'h120, alu_c);
        expect_e(64'h124, alu_c);
        peek("t5_held", 64'h120, 4'd6, 1'b0);
        idle(2'd0);
        peek("t5_full", 64'h128, 4'd8, 1'b0);
        check("t5_full_valid", 64'(out_valid), 64'h3);
        repeat (4) idle(2'd2);
        idle(2'd0);
        peek("t5_drain", 64'h128, 4'd0, 1'b0);

        // Redirect out of HALTED with a discarded dequeue
        redir(64'h30, 2'd0);
        fetch(64'h30, alu_c, alu_c, 2'd0);
        expect_e(64'h30, alu_c);
        expect_e(64'h34, alu_c);
        fetch(64'h38, hlt_c, alu_c, 2'd0);
        expect_e(64'h38, hlt_c);
        idle(2'd0);
        peek("t6_halt", 64'h38, 4'd3, 1'b1);
        redir(64'h200, 2'd2);
        idle(2'd0);
        peek("t6_redir", 64'h200, 4'd0, 1'b0);
        check("t6_out_valid", 64'(out_valid), 64'h0);
        fetch(64'h200, alu_c, alu_c, 2'd0);
        expect_e(64'h200, alu_c);
        expect_e(64'h204, alu_c);
        idle(2'd0);
        peek("t6_resume", 64'h208, 4'd2, 1'b0);
        idle(2'd2);

        // Reset wins over a simultaneous redirect and pending enqueue
        fetch(64'h208, alu_c, alu_c, 2'd0);
        @(negedge clock);
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h500;
        exp_q.delete();
        @(posedge clock);
        #1;
        reset                = 1'b0;
        redirect_valid       = 1'b0;
        imem.imem2proc_valid = 1'b0;
        peek("t7_reset", 64'h0, 4'd0, 1'b0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
